ifr_cnt_fsm: RTL and testbench

- Read-side counterpart of the ifmap buffer write path.
- Walks one ifmap buffer row by row. Each row is a sequence of columns; each column is a sequence of words.
- Generates SRAM read enables and addresses for the words it reads.
- Inserts zero-padding columns on the left or right edge, as selected by the master config state.
- Delivers every word (real or pad) to the PE feeder over a valid/ready stream.

---
 rtl/ifr_cnt_fsm.sv | 167 ++++++++++++++++
 tb/tb_ifr_cnt_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifr_cnt_fsm.sv
// Ifmap buffer read sequencer: walks columns/words of a row, inserts left/right pad columns, streams beats.
// Latency: issue to dout_valid is 1 cycle, 1 beat/cycle; rd_ready low freezes issue, address and SRAM read.
// Optional IFR_STALL_CNT_EN builds a saturating stall-cycle counter on dout_stall_cnt (tied to 0 otherwise).
module ifr_cnt_fsm #(
    parameter int CNT00_WIDTH   = 10,
    parameter int CNT01_WIDTH   = 10,
    parameter int RS_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_idle2start,
    input  logic [2:0]               din_cfg_mast_state,
    input  logic                     din_row_last,
    input  logic [CNT00_WIDTH-1:0]   rd_cnt00_finalnum,
    input  logic [CNT01_WIDTH-1:0]   rd_cnt01_finalnum,
    input  logic [RS_ADDR_WIDTH-1:0] rd_srad_finalnum,
    output logic                     sram_ren,
    output logic [RS_ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0]    sram_rdata,
    input  logic                     rd_ready,
    output logic                     dout_valid,
    output logic [DATA_WIDTH-1:0]    dout_data,
    output logic                     dout_pad,
    output logic [2:0]               dout_rd_curr_state,
    output logic [CNT00_WIDTH-1:0]   dout_rd_cnt00,
    output logic [CNT01_WIDTH-1:0]   dout_rd_cnt01,
    output logic                     dout_rd_stg0_last,
    output logic                     dout_rd_stg1_last,
    output logic                     dout_rd_done,
    output logic [15:0]              dout_stall_cnt
);

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_NORMAL = 3'd1,
        RD_LEFT   = 3'd2,
        RD_RIGH   = 3'd3,
        RD_DONE   = 3'd4
    } rd_state_e;

    localparam logic [2:0] CFG_LEFT   = 3'd1;
    localparam logic [2:0] CFG_NORMAL = 3'd2;
    localparam logic [2:0] CFG_RIGH   = 3'd3;

    rd_state_e                state_q, state_d, row_end_state;
    logic [CNT00_WIDTH-1:0]   cnt00_q, cnt00_d;
    logic [CNT01_WIDTH-1:0]   cnt01_q, cnt01_d;
    logic [RS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                     vld_q, vld_d;
    logic                     pad_q, pad_d;
    logic                     active, issue, start, stg0_last, stg1_last, cnt01_penult;

    assign active       = (state_q == RD_LEFT) || (state_q == RD_NORMAL) || (state_q == RD_RIGH);
    assign issue        = active && (!vld_q || rd_ready);
    assign start        = (state_q == RD_IDLE) && din_idle2start;
    assign stg0_last    = (cnt00_q == rd_cnt00_finalnum);
    assign stg1_last    = (cnt01_q == rd_cnt01_finalnum);
    assign cnt01_penult = (cnt01_q == (rd_cnt01_finalnum - CNT01_WIDTH'(1)));

    // End of a full row: finish the set on the last row, otherwise re-enter the row's first column type.
    assign row_end_state = din_row_last ? RD_DONE :
                           (din_cfg_mast_state == CFG_LEFT) ? RD_LEFT : RD_NORMAL;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (din_idle2start)
                    state_d = (din_cfg_mast_state == CFG_LEFT) ? RD_LEFT : RD_NORMAL;
            end
            RD_LEFT: begin
                if (issue && stg0_last)
                    state_d = stg1_last ? row_end_state : RD_NORMAL;
            end
            RD_NORMAL: begin
                if (issue) begin
                    case (din_cfg_mast_state)
                        CFG_LEFT, CFG_NORMAL: if (stg0_last && stg1_last) state_d = row_end_state;
                        CFG_RIGH:             if (stg0_last && cnt01_penult) state_d = RD_RIGH;
                        default:              state_d = RD_IDLE;
                    endcase
                end
            end
            RD_RIGH: begin
                if (issue && stg0_last && stg1_last)
                    state_d = din_row_last ? RD_DONE : RD_NORMAL;
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        cnt00_d = cnt00_q;
        cnt01_d = cnt01_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        pad_d   = pad_q;
        if (start) begin
            cnt00_d = '0;
            cnt01_d = '0;
        end else if (issue) begin
            cnt00_d = stg0_last ? '0 : cnt00_q + CNT00_WIDTH'(1);
            if (stg0_last)
                cnt01_d = stg1_last ? '0 : cnt01_q + CNT01_WIDTH'(1);
        end
        if (sram_ren)
            addr_d = (addr_q == rd_srad_finalnum) ? '0 : addr_q + RS_ADDR_WIDTH'(1);
        if (issue) begin
            vld_d = 1'b1;
            pad_d = (state_q != RD_NORMAL);
        end else if (rd_ready) begin
            vld_d = 1'b0;
            pad_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RD_IDLE;
            cnt00_q <= '0;
            cnt01_q <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt00_q <= cnt00_d;
            cnt01_q <= cnt01_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            pad_q   <= pad_d;
        end
    end

    assign sram_ren           = issue && (state_q == RD_NORMAL);
    assign sram_raddr         = addr_q;
    assign dout_valid         = vld_q;
    assign dout_pad           = pad_q;
    // SRAM data is held until the next read, and no read is issued while a beat is stalled.
    assign dout_data          = (vld_q && !pad_q) ? sram_rdata : '0;
    assign dout_rd_curr_state = state_q;
    assign dout_rd_cnt00      = cnt00_q;
    assign dout_rd_cnt01      = cnt01_q;
    assign dout_rd_stg0_last  = stg0_last;
    assign dout_rd_stg1_last  = stg1_last;
    assign dout_rd_done       = (state_q == RD_DONE);

`ifdef IFR_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else if (start)
            stall_q <= '0;
        else if (vld_q && !rd_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign dout_stall_cnt = stall_q;
`else
    assign dout_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifr_cnt_fsm.sv
// Bench for ifr_cnt_fsm: row-set walks in each edge mode against a column/word list model, with backpressure and reset.
module tb_ifr_cnt_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din_idle2start = 1'b0;
    logic [2:0]  din_cfg_mast_state = 3'd2;
    logic        din_row_last = 1'b0;
    logic [9:0]  rd_cnt00_finalnum = '0;
    logic [9:0]  rd_cnt01_finalnum = '0;
    logic [9:0]  rd_srad_finalnum = '0;
    logic        sram_ren;
    logic [9:0]  sram_raddr;
    logic [63:0] sram_rdata = '0;
    logic        rd_ready = 1'b1;
    logic        dout_valid;
    logic [63:0] dout_data;
    logic        dout_pad;
    logic [2:0]  dout_rd_curr_state;
    logic [9:0]  dout_rd_cnt00;
    logic [9:0]  dout_rd_cnt01;
    logic        dout_rd_stg0_last;
    logic        dout_rd_stg1_last;
    logic        dout_rd_done;
    logic [15:0] dout_stall_cnt;

    ifr_cnt_fsm dut (
        .clk(clk), .reset(reset), .din_idle2start(din_idle2start),
        .din_cfg_mast_state(din_cfg_mast_state), .din_row_last(din_row_last),
        .rd_cnt00_finalnum(rd_cnt00_finalnum), .rd_cnt01_finalnum(rd_cnt01_finalnum),
        .rd_srad_finalnum(rd_srad_finalnum), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata), .rd_ready(rd_ready), .dout_valid(dout_valid),
        .dout_data(dout_data), .dout_pad(dout_pad), .dout_rd_curr_state(dout_rd_curr_state),
        .dout_rd_cnt00(dout_rd_cnt00), .dout_rd_cnt01(dout_rd_cnt01),
        .dout_rd_stg0_last(dout_rd_stg0_last), .dout_rd_stg1_last(dout_rd_stg1_last),
        .dout_rd_done(dout_rd_done), .dout_stall_cnt(dout_stall_cnt)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [1024];
    always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_raddr];

    int vectors = 0;
    int errs = 0;

    int          exp_addr[$];
    int          exp_states[$];
    int          exp_ren[$];
    logic        obs_pad[$];
    logic [63:0] obs_data[$];
    int          obs_addr[$];
    int          obs_states[$];
    logic [63:0] st_data[$];
    int          st_addr[$];
    int          st_ren, stall_cycles, done_cnt, done_issued;
    logic        done_vld, timed_out;

    function automatic logic [15:0] exp_stall(input int n);
`ifdef IFR_STALL_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_data(input int a);
        return (a < 0) ? 64'd0 : mem[a];
    endfunction

    function automatic void push_state(input int s);
        if (exp_states.size() == 0 || exp_states[$] != s) exp_states.push_back(s);
    endfunction

    // Row-set as a list: per row, columns left to right, pad column first (LEFT) or last (RIGH).
    function automatic void build_model(input int cfg, input int c0, input int c1, input int srad, input int nrows);
        int a;
        a = 0;
        exp_addr.delete(); exp_states.delete(); exp_ren.delete();
        push_state(0);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c <= c1; c++) begin
                for (int w = 0; w <= c0; w++) begin
                    if ((cfg == 1 && c == 0) || (cfg == 3 && c == c1)) exp_addr.push_back(-1);
                    else begin
                        exp_addr.push_back(a);
                        exp_ren.push_back(a);
                        a = (a == srad) ? 0 : a + 1;
                    end
                end
            end
            if (cfg == 1) begin push_state(2); push_state(1); end
            else if (cfg == 3) begin push_state(1); push_state(3); end
            else push_state(1);
        end
        push_state(4);
        push_state(0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        din_idle2start = 1'b0;
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drives one row-set and records what the DUT produced; ready_mode 0=always, 1=random, 2=low on cycles 4..6.
    task automatic run_set(input int cfg, input int c0, input int c1, input int srad, input int nrows, input int ready_mode);
        int acc, issued, beats, last_state;
        logic finished;
        obs_pad.delete(); obs_data.delete(); obs_addr.delete(); obs_states.delete();
        st_data.delete(); st_addr.delete();
        st_ren = 0; stall_cycles = 0; done_cnt = 0; done_issued = -1; done_vld = 1'b0;
        finished = 1'b0; acc = 0; last_state = -1;
        beats = (c0 + 1) * (c1 + 1);
        din_cfg_mast_state = 3'(cfg);
        rd_cnt00_finalnum = 10'(c0);
        rd_cnt01_finalnum = 10'(c1);
        rd_srad_finalnum = 10'(srad);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            din_idle2start = (cyc == 0);
            issued = acc + int'(dout_valid);
            din_row_last = (nrows == 1) || (issued >= beats * (nrows - 1));
            case (ready_mode)
                1: rd_ready = ($urandom_range(0, 99) < 70);
                2: rd_ready = !(cyc >= 4 && cyc <= 6);
                default: rd_ready = 1'b1;
            endcase
            #1;
            if (int'(dout_rd_curr_state) != last_state) begin
                last_state = int'(dout_rd_curr_state);
                obs_states.push_back(last_state);
            end
            if (sram_ren) obs_addr.push_back(int'(sram_raddr));
            if (dout_valid && !rd_ready) stall_cycles++;
            if (ready_mode == 2 && !rd_ready) begin
                st_data.push_back(dout_data);
                st_addr.push_back(int'(sram_raddr));
                st_ren += int'(sram_ren);
            end
            if (dout_rd_done) begin
                done_cnt++;
                done_issued = acc + int'(dout_valid);
                done_vld = dout_valid;
            end
            if (dout_valid && rd_ready) begin
                obs_pad.push_back(dout_pad);
                obs_data.push_back(dout_data);
                acc++;
            end
            if (done_cnt > 0 && !dout_valid && dout_rd_curr_state == 3'd0) begin
                finished = 1'b1;
                break;
            end
        end
        din_idle2start = 1'b0;
        rd_ready = 1'b1;
        timed_out = !finished;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (dout_rd_curr_state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", dout_rd_curr_state); end
        vectors++; if (dout_valid !== 1'b0 || dout_pad !== 1'b0) begin errs++; $display("FAIL reset_vld_pad got %b%b exp 00", dout_valid, dout_pad); end
        vectors++; if (sram_ren !== 1'b0 || sram_raddr !== 10'd0) begin errs++; $display("FAIL reset_sram got ren %b addr %0d exp 0/0", sram_ren, sram_raddr); end
        vectors++; if (dout_rd_cnt00 !== 10'd0 || dout_rd_cnt01 !== 10'd0) begin errs++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", dout_rd_cnt00, dout_rd_cnt01); end
        vectors++; if (dout_data !== 64'd0 || dout_rd_done !== 1'b0 || dout_stall_cnt !== 16'd0) begin errs++; $display("FAIL reset_misc got data %h done %b stall %0d exp 0", dout_data, dout_rd_done, dout_stall_cnt); end
    endtask

    task automatic test_stream(input string name, input int cfg, input int c0, input int c1, input int srad, input int nrows, input int ready_mode);
        do_reset();
        build_model(cfg, c0, c1, srad, nrows);
        run_set(cfg, c0, c1, srad, nrows, ready_mode);
        vectors++; if (timed_out !== 1'b0) begin errs++; $display("FAIL %s timeout got done_cnt %0d exp row-set completion", name, done_cnt); end
        vectors++; if (obs_data.size() != exp_addr.size()) begin errs++; $display("FAIL %s beat_count got %0d exp %0d", name, obs_data.size(), exp_addr.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_pad[i] !== (exp_addr[i] < 0) || obs_data[i] !== exp_data(exp_addr[i])) begin
                errs++;
                $display("FAIL %s beat%0d got pad %b data %h exp pad %b data %h", name, i, obs_pad[i], obs_data[i], exp_addr[i] < 0, exp_data(exp_addr[i]));
            end
        end
        vectors++; if (obs_addr.size() != exp_ren.size()) begin errs++; $display("FAIL %s ren_count got %0d exp %0d", name, obs_addr.size(), exp_ren.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_ren.size(); i++) begin
            vectors++; if (obs_addr[i] != exp_ren[i]) begin errs++; $display("FAIL %s raddr%0d got %0d exp %0d", name, i, obs_addr[i], exp_ren[i]); end
        end
        vectors++; if (done_cnt != 1 || done_issued != exp_addr.size()) begin errs++; $display("FAIL %s done got pulses %0d after %0d issues exp 1 after %0d", name, done_cnt, done_issued, exp_addr.size()); end
        if (ready_mode == 0) begin
            vectors++; if (done_vld !== 1'b1) begin errs++; $display("FAIL %s done_timing got last beat valid %b exp 1", name, done_vld); end
        end
        vectors++; if (obs_states.size() != exp_states.size()) begin errs++; $display("FAIL %s state_count got %0d exp %0d", name, obs_states.size(), exp_states.size()); end
        for (int i = 0; i < obs_states.size() && i < exp_states.size(); i++) begin
            vectors++; if (obs_states[i] != exp_states[i]) begin errs++; $display("FAIL %s state%0d got %0d exp %0d", name, i, obs_states[i], exp_states[i]); end
        end
        vectors++; if (dout_stall_cnt !== exp_stall(stall_cycles)) begin errs++; $display("FAIL %s stall_cnt got %0d exp %0d", name, dout_stall_cnt, exp_stall(stall_cycles)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        build_model(2, 3, 1, 1023, 1);
        run_set(2, 3, 1, 1023, 1, 2);
        vectors++; if (timed_out !== 1'b0 || obs_data.size() != 8) begin errs++; $display("FAIL bp_complete got %0d beats timeout %b exp 8 beats", obs_data.size(), timed_out); end
        vectors++; if (st_data.size() != 3 || stall_cycles != 3) begin errs++; $display("FAIL bp_window got %0d low cycles %0d stalls exp 3/3", st_data.size(), stall_cycles); end
        for (int i = 0; i < st_data.size(); i++) begin
            vectors++; if (st_data[i] !== mem[exp_addr[2]] || st_addr[i] != exp_addr[3]) begin errs++; $display("FAIL bp_hold%0d got data %h addr %0d exp %h/%0d", i, st_data[i], st_addr[i], mem[exp_addr[2]], exp_addr[3]); end
        end
        vectors++; if (st_ren != 0) begin errs++; $display("FAIL bp_ren got %0d reads while stalled exp 0", st_ren); end
        for (int i = 0; i < obs_data.size() && i < 8; i++) begin
            vectors++; if (obs_data[i] !== mem[exp_addr[i]]) begin errs++; $display("FAIL bp_beat%0d got %h exp %h", i, obs_data[i], mem[exp_addr[i]]); end
        end
        vectors++; if (dout_stall_cnt !== exp_stall(3)) begin errs++; $display("FAIL bp_stall_cnt got %0d exp %0d", dout_stall_cnt, exp_stall(3)); end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        found = 1'b0;
        din_cfg_mast_state = 3'd2;
        rd_cnt00_finalnum = 10'd2;
        rd_cnt01_finalnum = 10'd1;
        rd_srad_finalnum = 10'd1023;
        din_row_last = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            din_idle2start = (cyc == 0);
            #1;
            if (dout_rd_curr_state == 3'd1 && dout_rd_cnt00 == 10'd1) begin found = 1'b1; break; end
        end
        din_idle2start = 1'b0;
        vectors++; if (found !== 1'b1) begin errs++; $display("FAIL rmid_reach got no NORMAL cnt00=1 exp reached"); end
        reset = 1'b0;
        #1;
        vectors++; if (dout_rd_curr_state !== 3'd0 || dout_rd_cnt00 !== 10'd0 || dout_rd_cnt01 !== 10'd0) begin errs++; $display("FAIL rmid_async_state got st %0d cnt %0d/%0d exp 0", dout_rd_curr_state, dout_rd_cnt00, dout_rd_cnt01); end
        vectors++; if (dout_valid !== 1'b0 || sram_ren !== 1'b0 || sram_raddr !== 10'd0 || dout_data !== 64'd0) begin errs++; $display("FAIL rmid_async_out got vld %b ren %b addr %0d data %h exp 0", dout_valid, sram_ren, sram_raddr, dout_data); end
        @(negedge clk);
        reset = 1'b1;
        build_model(2, 2, 1, 1023, 1);
        run_set(2, 2, 1, 1023, 1, 0);
        vectors++; if (obs_addr.size() == 0 || obs_addr[0] != 0) begin errs++; $display("FAIL rmid_restart got %0d reads first %0d exp first 0", obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1); end
        vectors++; if (obs_data.size() != 6 || timed_out !== 1'b0) begin errs++; $display("FAIL rmid_beats got %0d exp 6", obs_data.size()); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_stream("normal", 2, 2, 1, 1023, 1, 0);
        test_stream("left", 1, 1, 2, 1023, 1, 0);
        test_stream("righ", 3, 1, 2, 1023, 1, 0);
        test_backpressure();
        test_stream("two_rows", 1, 1, 2, 5, 2, 0);
        for (int k = 0; k < 8; k++) begin
            test_stream("random", int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                        int'($urandom_range(2, 12)), int'($urandom_range(1, 3)), 1);
        end
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
